// File: rtl/ccff_pkg.sv
// Shared types and helpers for the configuration-chain loader.
package ccff_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    LOAD = 2'd2,
    DONE = 2'd3
  } ccff_state_t;

  localparam logic [7:0] SYNC_PAT_DEFAULT = 8'hA5;

  // Words needed to cover the whole chain; the last one may be only partly used.
  function automatic int unsigned ccffWordCount(input int unsigned chainLen,
                                                input int unsigned wordW);
    return (chainLen + wordW - 1) / wordW;
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Word buffer that turns valid/ready configuration words into a bit stream, MSB first.
module ccff_word_serializer
  import ccff_pkg::*;
#(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned NUM_WORDS = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              accept_en_i,
  input  logic              cfg_valid_i,
  input  logic [WORD_W-1:0] cfg_data_i,
  output logic              cfg_ready_o,
  output logic              bit_valid_o,
  output logic              bit_data_o,
  input  logic              bit_take_i
);

  localparam int unsigned BCNT_W = $clog2(WORD_W + 1);
  localparam int unsigned WCNT_W = $clog2(NUM_WORDS + 1);

  logic [WORD_W-1:0] shiftBuf_q, shiftBuf_d;
  logic [BCNT_W-1:0] bitCnt_q, bitCnt_d;
  logic [WCNT_W-1:0] wordsLeft_q, wordsLeft_d;
  logic              empty;
  logic              handshake;

  // An arriving word can be used in the same cycle it is accepted.
  assign empty       = (bitCnt_q == '0);
  assign cfg_ready_o = accept_en_i && empty && (wordsLeft_q != '0);
  assign handshake   = cfg_valid_i && cfg_ready_o;
  assign bit_valid_o = !empty || handshake;
  assign bit_data_o  = empty ? cfg_data_i[WORD_W-1] : shiftBuf_q[WORD_W-1];

  always_comb begin
    shiftBuf_d  = shiftBuf_q;
    bitCnt_d    = bitCnt_q;
    wordsLeft_d = wordsLeft_q;
    if (clear_i) begin
      bitCnt_d    = '0;
      wordsLeft_d = WCNT_W'(NUM_WORDS);
    end else if (handshake) begin
      wordsLeft_d = wordsLeft_q - 1'b1;
      if (bit_take_i) begin
        shiftBuf_d = cfg_data_i << 1;
        bitCnt_d   = BCNT_W'(WORD_W - 1);
      end else begin
        shiftBuf_d = cfg_data_i;
        bitCnt_d   = BCNT_W'(WORD_W);
      end
    end else if (bit_take_i && !empty) begin
      shiftBuf_d = shiftBuf_q << 1;
      bitCnt_d   = bitCnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shiftBuf_q  <= '0;
      bitCnt_q    <= '0;
      wordsLeft_q <= '0;
    end else begin
      shiftBuf_q  <= shiftBuf_d;
      bitCnt_q    <= bitCnt_d;
      wordsLeft_q <= wordsLeft_d;
    end
  end

endmodule

// File: rtl/ccff_loader.sv
// Loads a configuration flip-flop chain: sync preamble, serialised words, and a tail check
// that the preamble made it through the whole chain.
module ccff_loader
  import ccff_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 1024,
  parameter int unsigned WORD_W    = 32,
  parameter logic [7:0]  SYNC_PAT  = SYNC_PAT_DEFAULT
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic              cfg_valid,
  input  logic [WORD_W-1:0] cfg_data,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              pass
);

  localparam int unsigned NUM_WORDS = ccffWordCount(CHAIN_LEN, WORD_W);
  localparam int unsigned CNT_W     = $clog2(CHAIN_LEN + 8);

  ccff_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             head_q, head_d;
  logic             shiftEn_q, shiftEn_d;
  logic             err_q, err_d;

  logic             finalShift;
  logic             loadPhase;
  logic [CNT_W-1:0] nextK;
  logic [2:0]       tailIdx;
  logic             serClear;
  logic             bitValid;
  logic             bitData;
  logic             bitTake;

  // cnt_q counts completed shift cycles, so nextK is the index of the next one to present.
  assign busy       = (state_q == SYNC) || (state_q == LOAD);
  assign done       = (state_q == DONE);
  assign pass       = done && !err_q;
  assign finalShift = shiftEn_q && (cnt_q == CNT_W'(CHAIN_LEN + 7));
  assign nextK      = cnt_q + CNT_W'(shiftEn_q);
  assign loadPhase  = busy && !finalShift && (nextK >= CNT_W'(8));
  assign bitTake    = loadPhase && bitValid;
  assign tailIdx    = cnt_q[2:0] - 3'(CHAIN_LEN);
  assign serClear   = !busy && start;

  assign ccff_head     = head_q;
  assign ccff_shift_en = shiftEn_q;

  ccff_word_serializer #(
    .WORD_W   (WORD_W),
    .NUM_WORDS(NUM_WORDS)
  ) u_serializer (
    .clk_i      (prog_clk),
    .rst_ni     (pReset_n),
    .clear_i    (serClear),
    .accept_en_i(loadPhase),
    .cfg_valid_i(cfg_valid),
    .cfg_data_i (cfg_data),
    .cfg_ready_o(cfg_ready),
    .bit_valid_o(bitValid),
    .bit_data_o (bitData),
    .bit_take_i (bitTake)
  );

  // Outputs are computed one cycle ahead so head/shift-enable come straight from flops.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    head_d    = head_q;
    shiftEn_d = 1'b0;
    err_d     = err_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = SYNC;
          cnt_d     = '0;
          err_d     = 1'b0;
          head_d    = SYNC_PAT[7];
          shiftEn_d = 1'b1;
        end
      end
      SYNC, LOAD: begin
        if (shiftEn_q && (cnt_q >= CNT_W'(CHAIN_LEN)) &&
            (ccff_tail != SYNC_PAT[3'd7 - tailIdx])) begin
          err_d = 1'b1;
        end
        if (finalShift) begin
          state_d = DONE;
        end else begin
          cnt_d = nextK;
          if (nextK < CNT_W'(8)) begin
            state_d   = SYNC;
            head_d    = SYNC_PAT[3'd7 - nextK[2:0]];
            shiftEn_d = 1'b1;
          end else begin
            state_d   = LOAD;
            shiftEn_d = bitValid;
            if (bitValid) begin
              head_d = bitData;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      head_q    <= 1'b0;
      shiftEn_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      head_q    <= head_d;
      shiftEn_q <= shiftEn_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: doc/ccff_loader.md
# ccff_loader

Configuration-chain loader that sits directly upstream of the I/O and logic tiles' configuration flip-flop chain: it drives `ccff_head` of the first tile and observes `ccff_tail` of the last. It accepts configuration words over a valid/ready stream and serialises them MSB-first into the chain under a shift-enable that gates the tiles' `prog_clk`. It prepends an 8-bit sync pattern to every load and checks it at the chain tail, giving a pass/fail integrity result per load.

## Interface
- `CHAIN_LEN`, 1024: number of configuration flip-flops in the chain; must be at least 8.
- `WORD_W`, 32: width of input configuration words.
- `SYNC_PAT`, 8'hA5: preamble shifted before the configuration bits, MSB first.
- `prog_clk` input 1: programming clock; all state on rising edge.
- `pReset_n` input 1: asynchronous, active-low reset.
- `start` input 1: single-cycle request to begin a load; honoured only in IDLE or DONE.
- `cfg_valid` input 1: configuration word available.
- `cfg_data` input WORD_W: configuration word; bit WORD_W-1 is shifted first.
- `cfg_ready` output 1: word accepted when `cfg_valid && cfg_ready`.
- `ccff_head` output 1: serial data into the chain head.
- `ccff_shift_en` output 1: enables the external clock gate on the chain's `prog_clk`; chain advances one bit per cycle it is high.
- `ccff_tail` input 1: chain tail, which is the last flip-flop's output.
- `busy` output 1: high in SYNC and LOAD.
- `done` output 1: high in DONE.
- `pass` output 1: valid while `done`; 1 iff all 8 tail samples matched `SYNC_PAT`.

## Operation
- **States:**
  - **IDLE.** Moves to SYNC on `start`.
  - **SYNC.** Lasts 8 shift cycles.
  - **LOAD.** Lasts exactly CHAIN_LEN shift cycles.
  - **DONE.** Moves to SYNC on `start`.
- **Shift counter.**
  - Width is clog2(CHAIN_LEN+8).
  - It counts shift cycles k = 0 … CHAIN_LEN+7 across SYNC and LOAD, and clears on entry to SYNC.
- **SYNC.**
  - `ccff_head` = `SYNC_PAT[7-k]`.
  - `ccff_shift_en` = 1 every cycle.
  - No words are consumed.
- **LOAD.**
  - A WORD_W-bit shift buffer holds the current word, plus a bit-count register.
  - When the buffer is empty, `cfg_ready` = 1.
  - A word is accepted the cycle after the buffer empties, or in the last SYNC cycle for the first word.
  - Shifting occurs only while the buffer holds a bit.
  - If no bit is available (the stream has stalled), `ccff_shift_en` = 0 and `ccff_head` holds its value. The chain is frozen and the counter does not advance.
- **Word count.** ceil(CHAIN_LEN/WORD_W) words are consumed per load.
  - Only CHAIN_LEN − WORD_W·(words−1) leading bits of the last word are shifted; its trailing bits are discarded.
  - `cfg_ready` stays 0 once the last word is accepted.
- **Tail check.**
  - At shift cycles k = CHAIN_LEN … CHAIN_LEN+7 (the last 8 of LOAD), `ccff_tail` is compared with `SYNC_PAT[7-(k-CHAIN_LEN)]`.
  - Any mismatch sets a sticky error flag, which is cleared on entry to SYNC.
  - `pass` = !error in DONE.
- **After the final shift cycle, enter DONE.**
  - `ccff_shift_en` = 0.
  - `cfg_ready` = 0.
  - The chain holds the configuration.
- **Ignored `start`.** `start` while busy is ignored.
- **Unconsumed `cfg_valid`.** `cfg_valid` in IDLE or DONE is not consumed.

## Timing
- **Reset values.** All outputs are 0 in reset: `ccff_head`, `ccff_shift_en`, `cfg_ready`, `busy`, `done`, `pass`. The state is IDLE.
- **Reset mid-load.** Reset during SYNC or LOAD aborts the load immediately. Chain contents are undefined and a new load is required.
- **Registered outputs.** `ccff_head` and `ccff_shift_en` are registered.
  - The first shift cycle is the cycle after `start` is sampled.
  - The chain captures `ccff_head` at the edge ending each cycle with `ccff_shift_en` = 1.
- **Tail sampling.** `ccff_tail` is sampled on the same edge that the chain shifts, so the sampled value is the pre-shift last flip-flop.
- **Status timing.**
  - `done` and `pass` assert one cycle after the final shift cycle.
  - `busy` deasserts in the same cycle.
- **Unstalled load length.** The first word must be valid by the last SYNC cycle; an unstalled load then takes CHAIN_LEN+8 shift cycles.
- **Stall cost.** Each cycle of `cfg_valid` = 0 while the buffer is empty adds one cycle with `ccff_shift_en` = 0.
- **Handshake.**
  - `cfg_data` is sampled only on the handshake.
  - Acceptance and the first shift of that word may occur in the same cycle: the handshake loads the buffer and the MSB is registered onto `ccff_head`.

## Structure
- **Shared package `ccff_pkg`.**
  - State enum `ccff_state_t` (IDLE, SYNC, LOAD, DONE).
  - Default `SYNC_PAT` constant.
  - A function computing the word count from CHAIN_LEN and WORD_W.
- **Sub-module `ccff_word_serializer`.**
  - Owns the WORD_W shift buffer and bit count, and the valid/ready side.
  - Presents a one-bit `bit_valid`/`bit_data`/`bit_take` interface to the FSM.
- **FSM, counter, tail comparator.** These stay in `ccff_loader`.

## Test plan
1. **Clean load.** CHAIN_LEN=40, WORD_W=32, chain modelled as a 40-bit gated shift register; start, then words 32'hDEADBEEF and 32'h12345678, valid every cycle.
   - Exactly 48 shift cycles; the chain holds DEADBEEF followed by 12 (upper 8 bits).
   - `done`=1, `pass`=1.
2. **Stalled stream.** As in scenario 1, with `cfg_valid` low for 5 cycles between words.
   - `ccff_shift_en` is low for exactly those 5 cycles and the chain is unchanged during them.
   - Final contents are identical to scenario 1; `pass`=1.
3. **Broken chain.** Tail model stuck at 0.
   - `done`=1 and `pass`=0 after 48 shift cycles.
4. **Restart after success.** `start` in DONE with new words 32'h0 and 32'hFFFFFFFF.
   - The sticky error flag is cleared; the chain holds 32 zeros then 8 ones; `pass`=1.
5. **Reset mid-load.** `pReset_n` low at shift cycle 20.
   - All outputs go to 0 asynchronously and the state is IDLE.
   - A subsequent `start` performs a full 48-cycle load with `pass`=1.
6. **Start while busy.** `start` pulsed while busy.
   - No restart; the shift counter and load length are unaffected.
